// File: rtl/da_bit_scheduler_pkg.sv
// Shared types and helpers for the DA bit-plane scheduler.
package da_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        HOLD
    } sched_state_e;

    localparam int unsigned T_W    = 8;
    localparam int unsigned MAX_DW = 1 << T_W;

    // Bit t of one element, zero-extended to the widest supported element.
    function automatic logic plane_bit(input logic [MAX_DW-1:0] elem,
                                       input logic [T_W-1:0]    t);
        return elem[t];
    endfunction

endpackage

// File: rtl/da_bit_scheduler_if.sv
// Valid/ready stream bundle used for the A-vector input and the result output.
interface da_stream_if #(
    parameter int unsigned W = 8
) ();
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/da_bit_scheduler_bitplane_mux.sv
// Combinational bit-plane select: bit t of every element -> {addr_array, A0}.
module da_bitplane_mux
    import da_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_A = 16,
    parameter int unsigned K            = 9
) (
    input  logic [K*DATA_WIDTH_A-1:0] vec,
    input  logic [T_W-1:0]            t,
    output logic                      a0,
    output logic [K-2:0]              addr
);

    logic [MAX_DW-1:0] elem;

    always_comb begin
        a0   = 1'b0;
        addr = '0;
        elem = '0;
        elem[DATA_WIDTH_A-1:0] = vec[DATA_WIDTH_A-1:0];
        a0 = plane_bit(elem, t);
        for (int unsigned i = 1; i < K; i++) begin
            elem = '0;
            elem[DATA_WIDTH_A-1:0] = vec[i*DATA_WIDTH_A +: DATA_WIDTH_A];
            addr[i-1] = plane_bit(elem, t);
        end
    end

endmodule

// File: rtl/da_bit_scheduler.sv
// DA LUT / shift-accumulate sequencer: accept A vector, stream bit-planes LSB->MSB, capture SA result.
// Optional DA_SCHED_PERF_EN adds perf_jobs / perf_stall counters.
module da_bit_scheduler
    import da_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_A = 16,
    parameter int unsigned LUT_WIDTH    = 20,
    parameter int unsigned K            = 9,
    parameter int unsigned SA_LAT       = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    da_stream_if.slave           a_if,
    da_stream_if.master          res_if,
    output logic                 gen_done,
    output logic                 A0,
    output logic [K-2:0]         addr_array,
    output logic [T_W-1:0]       t,
    output logic                 sa_first,
    output logic                 sa_last,
    input  logic [LUT_WIDTH-1:0] sa_c_out
`ifdef DA_SCHED_PERF_EN
    ,
    output logic [31:0]          perf_jobs,
    output logic [31:0]          perf_stall
`endif
);

    if (DATA_WIDTH_A < 1 || DATA_WIDTH_A > MAX_DW || K < 2 || SA_LAT < 1) begin : g_param_check
        $error("da_bit_scheduler: unsupported parameters");
    end

    localparam int unsigned         DCW    = $clog2(SA_LAT + 1);
    localparam logic [T_W-1:0]      T_LAST = T_W'(DATA_WIDTH_A - 1);

    sched_state_e                state_q, state_d;
    logic [K*DATA_WIDTH_A-1:0]   shadow_q, shadow_d;
    logic [DCW-1:0]              drain_q, drain_d;
    logic                        a_ready_q, a_ready_d;
    logic                        gen_done_q, gen_done_d;
    logic                        a0_q, a0_d;
    logic [K-2:0]                addr_q, addr_d;
    logic [T_W-1:0]              t_q, t_d;
    logic                        sa_first_q, sa_first_d;
    logic                        sa_last_q, sa_last_d;
    logic                        res_valid_q, res_valid_d;
    logic [LUT_WIDTH-1:0]        res_data_q, res_data_d;
`ifdef DA_SCHED_PERF_EN
    logic [31:0]                 perf_jobs_q, perf_jobs_d;
    logic [31:0]                 perf_stall_q, perf_stall_d;
`endif

    logic [K*DATA_WIDTH_A-1:0]   mux_vec;
    logic [T_W-1:0]              mux_t;
    logic                        plane_a0;
    logic [K-2:0]                plane_addr;

    // Outputs are registered, so the mux looks one plane ahead: at the
    // handshake it reads plane 0 straight from the bus, afterwards plane t+1 from the shadow.
    always_comb begin
        mux_vec = shadow_q;
        mux_t   = t_q + T_W'(1);
        if (state_q == IDLE) begin
            mux_vec = a_if.data;
            mux_t   = '0;
        end
    end

    da_bitplane_mux #(
        .DATA_WIDTH_A (DATA_WIDTH_A),
        .K            (K)
    ) u_mux (
        .vec  (mux_vec),
        .t    (mux_t),
        .a0   (plane_a0),
        .addr (plane_addr)
    );

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        drain_d     = drain_q;
        a_ready_d   = 1'b0;
        gen_done_d  = 1'b0;
        a0_d        = 1'b0;
        addr_d      = '0;
        t_d         = '0;
        sa_first_d  = 1'b0;
        sa_last_d   = 1'b0;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;

        unique case (state_q)
            IDLE: begin
                a_ready_d = 1'b1;
                if (a_if.valid && a_ready_q) begin
                    state_d    = RUN;
                    shadow_d   = a_if.data;
                    a_ready_d  = 1'b0;
                    gen_done_d = 1'b1;
                    a0_d       = plane_a0;
                    addr_d     = plane_addr;
                    sa_first_d = 1'b1;
                    sa_last_d  = (T_LAST == '0);
                end
            end
            RUN: begin
                if (t_q == T_LAST) begin
                    state_d = DRAIN;
                    drain_d = DCW'(SA_LAT);
                end else begin
                    gen_done_d = 1'b1;
                    t_d        = t_q + T_W'(1);
                    a0_d       = plane_a0;
                    addr_d     = plane_addr;
                    sa_last_d  = (t_q + T_W'(1) == T_LAST);
                end
            end
            DRAIN: begin
                if (drain_q == DCW'(1)) begin
                    state_d     = HOLD;
                    res_valid_d = 1'b1;
                    res_data_d  = sa_c_out;
                end else begin
                    drain_d = drain_q - DCW'(1);
                end
            end
            HOLD: begin
                if (res_if.ready) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                    a_ready_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef DA_SCHED_PERF_EN
    always_comb begin
        perf_jobs_d  = perf_jobs_q;
        perf_stall_d = perf_stall_q;
        if (state_q == HOLD) begin
            if (res_if.ready) perf_jobs_d  = perf_jobs_q + 32'd1;
            else              perf_stall_d = perf_stall_q + 32'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            shadow_q     <= '0;
            drain_q      <= '0;
            a_ready_q    <= 1'b1;
            gen_done_q   <= 1'b0;
            a0_q         <= 1'b0;
            addr_q       <= '0;
            t_q          <= '0;
            sa_first_q   <= 1'b0;
            sa_last_q    <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
`ifdef DA_SCHED_PERF_EN
            perf_jobs_q  <= '0;
            perf_stall_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            drain_q      <= drain_d;
            a_ready_q    <= a_ready_d;
            gen_done_q   <= gen_done_d;
            a0_q         <= a0_d;
            addr_q       <= addr_d;
            t_q          <= t_d;
            sa_first_q   <= sa_first_d;
            sa_last_q    <= sa_last_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
`ifdef DA_SCHED_PERF_EN
            perf_jobs_q  <= perf_jobs_d;
            perf_stall_q <= perf_stall_d;
`endif
        end
    end

    assign a_if.ready   = a_ready_q;
    assign res_if.valid = res_valid_q;
    assign res_if.data  = res_data_q;
    assign gen_done     = gen_done_q;
    assign A0           = a0_q;
    assign addr_array   = addr_q;
    assign t            = t_q;
    assign sa_first     = sa_first_q;
    assign sa_last      = sa_last_q;
`ifdef DA_SCHED_PERF_EN
    assign perf_jobs    = perf_jobs_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_da_bit_scheduler.sv
// Directed bench for da_bit_scheduler: plane table, latency, backpressure, mid-job reset.
module tb_da_bit_scheduler;

    localparam int unsigned DW     = 16;
    localparam int unsigned K      = 9;
    localparam int unsigned LW     = 20;
    localparam int unsigned SA_LAT = 1;

    localparam logic [LW-1:0] RES0 = 20'd947;
    localparam logic [LW-1:0] RES1 = 20'd852;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    da_stream_if #(.W(K*DW)) a_if ();
    da_stream_if #(.W(LW))   res_if ();

    logic          gen_done;
    logic          A0;
    logic [K-2:0]  addr_array;
    logic [7:0]    t;
    logic          sa_first;
    logic          sa_last;
    logic [LW-1:0] sa_c_out;
`ifdef DA_SCHED_PERF_EN
    logic [31:0]   perf_jobs;
    logic [31:0]   perf_stall;
`endif

    da_bit_scheduler #(
        .DATA_WIDTH_A (DW),
        .LUT_WIDTH    (LW),
        .K            (K),
        .SA_LAT       (SA_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .a_if       (a_if),
        .res_if     (res_if),
        .gen_done   (gen_done),
        .A0         (A0),
        .addr_array (addr_array),
        .t          (t),
        .sa_first   (sa_first),
        .sa_last    (sa_last),
        .sa_c_out   (sa_c_out)
`ifdef DA_SCHED_PERF_EN
        ,
        .perf_jobs  (perf_jobs),
        .perf_stall (perf_stall)
`endif
    );

    // SA stand-in: one register stage, running sum of {addr_array, A0} per plane.
    logic [LW-1:0] sa_acc = '0;
    always @(posedge clk) begin
        if (gen_done)
            sa_acc <= (sa_first ? '0 : sa_acc) + LW'({addr_array, A0});
    end
    assign sa_c_out = sa_acc;

    typedef struct {
        logic [7:0] t;
        logic       a0;
        logic [7:0] addr;
        logic       first;
        logic       last;
    } plane_t;

    plane_t          tbl [32];
    logic [K*DW-1:0] vec0;
    logic [K*DW-1:0] vec1;
    int              errors = 0;
    int              checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after the accepting edge; leaves the bench just after the 16th plane edge.
    task automatic check_planes(input int base, input string tag);
        for (int j = 0; j < 16; j++) begin
            chk($sformatf("%s_p%0d_gen_done", tag, j), 32'(gen_done), 32'd1);
            chk($sformatf("%s_p%0d_t", tag, j), 32'(t), 32'(tbl[base+j].t));
            chk($sformatf("%s_p%0d_A0", tag, j), 32'(A0), 32'(tbl[base+j].a0));
            chk($sformatf("%s_p%0d_addr", tag, j), 32'(addr_array), 32'(tbl[base+j].addr));
            chk($sformatf("%s_p%0d_first", tag, j), 32'(sa_first), 32'(tbl[base+j].first));
            chk($sformatf("%s_p%0d_last", tag, j), 32'(sa_last), 32'(tbl[base+j].last));
            chk($sformatf("%s_p%0d_a_ready", tag, j), 32'(a_if.ready), 32'd0);
            tick();
        end
        chk({tag, "_drain_gen_done"}, 32'(gen_done), 32'd0);
        chk({tag, "_drain_t"}, 32'(t), 32'd0);
        chk({tag, "_drain_res_valid"}, 32'(res_if.valid), 32'd0);
    endtask

`ifdef DA_SCHED_PERF_EN
    task automatic do_job(input logic [K*DW-1:0] v, input int stall);
        res_if.ready = (stall == 0);
        a_if.data    = v;
        a_if.valid   = 1'b1;
        tick();
        a_if.valid   = 1'b0;
        repeat (17) tick();
        repeat (stall) tick();
        res_if.ready = 1'b1;
        tick();
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            tbl[i].t     = 8'(i % 16);
            tbl[i].a0    = 1'b0;
            tbl[i].addr  = 8'h00;
            tbl[i].first = (i % 16 == 0);
            tbl[i].last  = (i % 16 == 15);
        end
        // job 0: element i = i+1
        tbl[0].a0  = 1'b1; tbl[0].addr  = 8'hAA;
        tbl[1].addr  = 8'h33;
        tbl[2].addr  = 8'h3C;
        tbl[3].addr  = 8'hC0;
        // job 1: even elements 16'h8001, odd elements 16'h4000
        tbl[16].a0 = 1'b1; tbl[16].addr = 8'hAA;
        tbl[30].addr = 8'h55;
        tbl[31].a0 = 1'b1; tbl[31].addr = 8'hAA;

        for (int i = 0; i < int'(K); i++) begin
            vec0[i*DW +: DW] = 16'(i + 1);
            vec1[i*DW +: DW] = (i % 2 == 0) ? 16'h8001 : 16'h4000;
        end

        // Reset with a_valid asserted
        a_if.valid   = 1'b1;
        a_if.data    = vec0;
        res_if.ready = 1'b0;
        rst          = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rst%0d_gen_done", c), 32'(gen_done), 32'd0);
            chk($sformatf("rst%0d_a_ready", c), 32'(a_if.ready), 32'd1);
        end
        @(negedge clk);
        a_if.valid = 1'b0;
        rst        = 1'b1;
        tick();
        chk("idle_a_ready", 32'(a_if.ready), 32'd1);
        chk("idle_gen_done", 32'(gen_done), 32'd0);
        chk("idle_A0", 32'(A0), 32'd0);
        chk("idle_addr", 32'(addr_array), 32'd0);
        chk("idle_t", 32'(t), 32'd0);
        chk("idle_first", 32'(sa_first), 32'd0);
        chk("idle_last", 32'(sa_last), 32'd0);
        chk("idle_res_valid", 32'(res_if.valid), 32'd0);
        chk("idle_res_data", 32'(res_if.data), 32'd0);

        // Job 0: planes and latency; bus data scrambled after the handshake
        a_if.data  = vec0;
        a_if.valid = 1'b1;
        tick();
        a_if.valid = 1'b0;
        a_if.data  = '1;
        check_planes(0, "job0");
        tick();
        chk("job0_res_valid", 32'(res_if.valid), 32'd1);
        chk("job0_res_data", 32'(res_if.data), 32'(RES0));

        // Backpressure with the next vector already offered
        a_if.data  = vec1;
        a_if.valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            chk($sformatf("bp%0d_res_valid", c), 32'(res_if.valid), 32'd1);
            chk($sformatf("bp%0d_res_data", c), 32'(res_if.data), 32'(RES0));
            chk($sformatf("bp%0d_a_ready", c), 32'(a_if.ready), 32'd0);
            chk($sformatf("bp%0d_gen_done", c), 32'(gen_done), 32'd0);
            tick();
        end
        res_if.ready = 1'b1;
        tick();
        chk("bp_rel_res_valid", 32'(res_if.valid), 32'd0);
        chk("bp_rel_a_ready", 32'(a_if.ready), 32'd1);
        chk("bp_rel_gen_done", 32'(gen_done), 32'd0);
        tick();
        a_if.valid = 1'b0;
        a_if.data  = '1;
        check_planes(16, "job1");
        tick();
        chk("job1_res_valid", 32'(res_if.valid), 32'd1);
        chk("job1_res_data", 32'(res_if.data), 32'(RES1));
        tick();
        chk("job1_hold1_res_valid", 32'(res_if.valid), 32'd0);
        chk("job1_hold1_a_ready", 32'(a_if.ready), 32'd1);

        // Mid-job asynchronous reset at t=7
        a_if.data  = vec1;
        a_if.valid = 1'b1;
        tick();
        a_if.valid = 1'b0;
        repeat (7) tick();
        chk("mid_t_before", 32'(t), 32'd7);
        chk("mid_gen_done_before", 32'(gen_done), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("mid_gen_done", 32'(gen_done), 32'd0);
        chk("mid_t", 32'(t), 32'd0);
        chk("mid_a_ready", 32'(a_if.ready), 32'd1);
        chk("mid_A0", 32'(A0), 32'd0);
        chk("mid_addr", 32'(addr_array), 32'd0);
        chk("mid_last", 32'(sa_last), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        a_if.data  = vec0;
        a_if.valid = 1'b1;
        tick();
        a_if.valid = 1'b0;
        a_if.data  = '1;
        check_planes(0, "job2");
        tick();
        chk("job2_res_valid", 32'(res_if.valid), 32'd1);
        chk("job2_res_data", 32'(res_if.data), 32'(RES0));
        tick();
        chk("job2_done_res_valid", 32'(res_if.valid), 32'd0);

`ifdef DA_SCHED_PERF_EN
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("perf_jobs_rst", perf_jobs, 32'd0);
        chk("perf_stall_rst", perf_stall, 32'd0);
        do_job(vec0, 2);
        do_job(vec1, 0);
        do_job(vec0, 3);
        chk("perf_jobs", perf_jobs, 32'd3);
        chk("perf_stall", perf_stall, 32'd5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
